// File: rtl/gyro_pkg.sv
// rtl/gyro_pkg.sv - shared constants and state types for the gyro packet receiver
package gyro_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'h55;
  localparam logic [7:0] TYPE_ANGLE  = 8'h53;
  localparam int         PAYLOAD_LEN = 8;
  localparam int         OVERSAMPLE  = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} rx_state_t;
  typedef enum logic [1:0] {HUNT, TYPE, PAYLOAD, CSUM} pkt_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 16x oversampled 8N1 byte receiver with synchronizer and prescaler
module uart_rx_byte
  import gyro_pkg::*;
#(
  parameter int CLK_DIV = 326
) (
  input  logic       clk0,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       uart_err_o
);

  localparam int              PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [3:0]      MID     = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      LAST    = 4'(OVERSAMPLE - 1);

  logic          sync1_q, sync2_q;
  logic [PW-1:0] pre_q;
  logic          tick;
  rx_state_t     state_q, state_d;
  logic [3:0]    scnt_q, scnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    byte_q, byte_d;
  logic          bvalid_q, bvalid_d;
  logic          uerr_q, uerr_d;
  logic          rxs;

  assign rxs  = sync2_q;
  assign tick = (pre_q == PRE_MAX);

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      pre_q    <= '0;
      state_q  <= IDLE;
      scnt_q   <= '0;
      bcnt_q   <= '0;
      shreg_q  <= '0;
      byte_q   <= '0;
      bvalid_q <= 1'b0;
      uerr_q   <= 1'b0;
    end else begin
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      pre_q    <= tick ? '0 : pre_q + 1'b1;
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      bcnt_q   <= bcnt_d;
      shreg_q  <= shreg_d;
      byte_q   <= byte_d;
      bvalid_q <= bvalid_d;
      uerr_q   <= uerr_d;
    end
  end

  // Start is confirmed at tick 7; afterwards every 16th tick lands mid-bit.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    byte_d   = byte_q;
    bvalid_d = 1'b0;
    uerr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          scnt_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (scnt_q == MID) begin
            scnt_d  = '0;
            bcnt_d  = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt_q == LAST) begin
            scnt_d          = '0;
            shreg_d[bcnt_q] = rxs;
            bcnt_d          = bcnt_q + 1'b1;
            if (bcnt_q == 3'd7) state_d = STOP;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (scnt_q == LAST) begin
            scnt_d = '0;
            if (rxs) begin
              bvalid_d = 1'b1;
              byte_d   = shreg_q;
              state_d  = IDLE;
            end else begin
              uerr_d  = 1'b1;
              state_d = WAITHI;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      WAITHI: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = bvalid_q;
  assign uart_err_o   = uerr_q;

endmodule

// File: rtl/gyro_packet_rx.sv
// rtl/gyro_packet_rx.sv - assembles checksummed 0x55 0x53 angle packets into output words
module gyro_packet_rx
  import gyro_pkg::*;
#(
  parameter int CLK_DIV = 326
) (
  input  logic        clk0,
  input  logic        rst_n,
  input  logic        probe,
  output logic [15:0] roll,
  output logic [15:0] pitch,
  output logic [15:0] yaw,
  output logic [15:0] temp,
  output logic        angle_valid,
  output logic        csum_err,
  output logic        uart_err
);

  localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_LEN - 1);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err;

  pkt_state_t  pstate_q, pstate_d;
  logic [7:0]  sum_q, sum_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  pbuf_q [PAYLOAD_LEN];
  logic        buf_we;
  logic        av_q, av_d;
  logic        ce_q, ce_d;
  logic [15:0] roll_q, pitch_q, yaw_q, temp_q;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk0         (clk0),
    .rst_n        (rst_n),
    .rx_i         (probe),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .uart_err_o   (rx_err)
  );

  always_comb begin
    pstate_d = pstate_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    buf_we   = 1'b0;
    av_d     = 1'b0;
    ce_d     = 1'b0;
    if (rx_err) begin
      pstate_d = HUNT;
    end else if (rx_valid) begin
      case (pstate_q)
        HUNT: begin
          if (rx_byte == SYNC_BYTE) begin
            pstate_d = TYPE;
            sum_d    = SYNC_BYTE;
          end
        end
        TYPE: begin
          if (rx_byte == TYPE_ANGLE) begin
            pstate_d = PAYLOAD;
            sum_d    = sum_q + rx_byte;
            idx_d    = '0;
          end else if (rx_byte == SYNC_BYTE) begin
            sum_d = SYNC_BYTE;
          end else begin
            pstate_d = HUNT;
          end
        end
        PAYLOAD: begin
          buf_we = 1'b1;
          sum_d  = sum_q + rx_byte;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LAST_IDX) pstate_d = CSUM;
        end
        CSUM: begin
          if (rx_byte == sum_q) av_d = 1'b1;
          else                  ce_d = 1'b1;
          pstate_d = HUNT;
        end
        default: pstate_d = HUNT;
      endcase
    end
  end

  // Words load on the same edge that raises angle_valid, so both appear together.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q <= HUNT;
      sum_q    <= '0;
      idx_q    <= '0;
      av_q     <= 1'b0;
      ce_q     <= 1'b0;
      roll_q   <= '0;
      pitch_q  <= '0;
      yaw_q    <= '0;
      temp_q   <= '0;
      for (int i = 0; i < PAYLOAD_LEN; i++) pbuf_q[i] <= '0;
    end else begin
      pstate_q <= pstate_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      av_q     <= av_d;
      ce_q     <= ce_d;
      if (buf_we) pbuf_q[idx_q] <= rx_byte;
      if (av_d) begin
        roll_q  <= {pbuf_q[1], pbuf_q[0]};
        pitch_q <= {pbuf_q[3], pbuf_q[2]};
        yaw_q   <= {pbuf_q[5], pbuf_q[4]};
        temp_q  <= {pbuf_q[7], pbuf_q[6]};
      end
    end
  end

  assign roll        = roll_q;
  assign pitch       = pitch_q;
  assign yaw         = yaw_q;
  assign temp        = temp_q;
  assign angle_valid = av_q;
  assign csum_err    = ce_q;
  assign uart_err    = rx_err;

endmodule

// File: tb/tb_gyro_packet_rx.sv
// tb/tb_gyro_packet_rx.sv - scoreboard bench for gyro_packet_rx with directed packets
module tb_gyro_packet_rx;

  localparam int CLK_DIV = 4;
  localparam int BIT     = 16 * CLK_DIV;

  localparam logic [1:0] EV_AV = 2'd0;
  localparam logic [1:0] EV_CE = 2'd1;
  localparam logic [1:0] EV_UE = 2'd2;

  localparam logic [87:0] PKT_A     = 88'h55_53_10_27_00_F0_34_12_00_00_15;
  localparam logic [87:0] PKT_A_BAD = 88'h55_53_10_27_00_F0_34_12_00_00_16;
  localparam logic [87:0] PKT_ACCEL = 88'h55_51_01_02_03_04_05_06_07_08_09;
  localparam logic [87:0] PKT_D     = 88'h55_53_01_02_03_04_05_06_07_08_CC;
  localparam logic [87:0] PKT_E     = 88'h55_53_11_22_33_44_55_66_77_88_0C;
  localparam logic [63:0] W_A = {16'h2710, 16'hF000, 16'h1234, 16'h0000};
  localparam logic [63:0] W_D = {16'h0201, 16'h0403, 16'h0605, 16'h0807};
  localparam logic [63:0] W_E = {16'h2211, 16'h4433, 16'h6655, 16'h8877};

  logic        clk0 = 1'b0;
  logic        rst_n = 1'b0;
  logic        probe = 1'b1;
  logic [15:0] roll, pitch, yaw, temp;
  logic        angle_valid, csum_err, uart_err;

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] words;
  } ev_t;

  ev_t         exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] cur_w = '0;

  always #5 clk0 = ~clk0;

  gyro_packet_rx #(.CLK_DIV(CLK_DIV)) dut (
    .clk0        (clk0),
    .rst_n       (rst_n),
    .probe       (probe),
    .roll        (roll),
    .pitch       (pitch),
    .yaw         (yaw),
    .temp        (temp),
    .angle_valid (angle_valid),
    .csum_err    (csum_err),
    .uart_err    (uart_err)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [63:0] w);
    ev_t e;
    e.kind  = k;
    e.words = w;
    exp_q.push_back(e);
    if (k == EV_AV) cur_w = w;
  endtask

  task automatic take(input logic [1:0] k);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_pulse kind=%0d words=%h expected no pulse", k,
               {roll, pitch, yaw, temp});
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.words !== {roll, pitch, yaw, temp}) begin
        n_err++;
        $display("FAIL pulse kind=%0d words=%h expected kind=%0d words=%h", k,
                 {roll, pitch, yaw, temp}, e.kind, e.words);
      end
    end
  endtask

  always @(negedge clk0) begin
    if (rst_n) begin
      if (angle_valid) take(EV_AV);
      if (csum_err)    take(EV_CE);
      if (uart_err)    take(EV_UE);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    probe = 1'b0;
    repeat (BIT) @(negedge clk0);
    for (int i = 0; i < 8; i++) begin
      probe = b[i];
      repeat (BIT) @(negedge clk0);
    end
    probe = ~bad_stop;
    repeat (BIT) @(negedge clk0);
    probe = 1'b1;
    if (bad_stop) repeat (BIT) @(negedge clk0);
  endtask

  task automatic send_pkt(input logic [87:0] p, input int n, input int bad_idx);
    for (int i = 0; i < n; i++) send_byte(p[87 - 8 * i -: 8], i == bad_idx);
  endtask

  task automatic drain(input string name);
    repeat (2 * BIT) @(negedge clk0);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk0);
    check("rst_words", {roll, pitch, yaw, temp}, 64'd0);
    check("rst_pulses", {61'd0, angle_valid, csum_err, uart_err}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk0);

    expect_ev(EV_AV, W_A);
    send_pkt(PKT_A, 11, -1);
    drain("good_drain");
    check("good_words", {roll, pitch, yaw, temp}, W_A);

    expect_ev(EV_CE, cur_w);
    send_pkt(PKT_A_BAD, 11, -1);
    drain("csum_drain");
    check("csum_words_kept", {roll, pitch, yaw, temp}, W_A);

    expect_ev(EV_AV, W_D);
    send_pkt(PKT_ACCEL, 11, -1);
    send_byte(8'h55, 1'b0);
    send_pkt(PKT_D, 11, -1);
    drain("resync_drain");
    check("resync_words", {roll, pitch, yaw, temp}, W_D);

    probe = 1'b0;
    repeat (5 * CLK_DIV) @(negedge clk0);
    probe = 1'b1;
    repeat (2 * BIT) @(negedge clk0);
    check("glitch_words", {roll, pitch, yaw, temp}, W_D);
    expect_ev(EV_AV, W_E);
    send_pkt(PKT_E, 11, -1);
    drain("glitch_drain");

    expect_ev(EV_UE, cur_w);
    send_pkt(PKT_A, 11, 5);
    drain("frame_drain");
    check("frame_words_kept", {roll, pitch, yaw, temp}, W_E);
    expect_ev(EV_AV, W_A);
    send_pkt(PKT_A, 11, -1);
    drain("after_frame_drain");

    send_pkt(PKT_D, 6, -1);
    @(negedge clk0);
    rst_n = 1'b0;
    #1;
    check("midrst_words", {roll, pitch, yaw, temp}, 64'd0);
    check("midrst_pulses", {61'd0, angle_valid, csum_err, uart_err}, 64'd0);
    cur_w = '0;
    repeat (4) @(negedge clk0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk0);
    expect_ev(EV_AV, W_E);
    send_pkt(PKT_E, 11, -1);
    drain("after_rst_drain");
    check("after_rst_words", {roll, pitch, yaw, temp}, W_E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
